// File: rtl/pea_result_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pea_result_drain
// Brief    : Pops result/status pairs from the PEA output FIFOs and streams
//            each pair as two valid/ready beats (result, then status).
// Revision : 1.0 - initial release
// ============================================================================
module pea_result_drain #(
   parameter int WIDTH = 32,
   parameter int POP_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             clear_cnt,
   input  logic [POP_W-1:0] result_pop,
   input  logic [POP_W-1:0] status_pop,
   input  logic [WIDTH-1:0] result_data,
   input  logic [WIDTH-1:0] status_data,
   output logic             rd_en_result,
   output logic             rd_en_status,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy,
   output logic [CNT_W-1:0] pair_count,
   output logic [CNT_W-1:0] err_count,
   output logic             desync
);

   localparam logic [2:0] c_IDLE      = 3'd0;
   localparam logic [2:0] c_POP       = 3'd1;
   localparam logic [2:0] c_WAIT      = 3'd2;
   localparam logic [2:0] c_SEND_RES  = 3'd3;
   localparam logic [2:0] c_SEND_STAT = 3'd4;

   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   logic [2:0]       r_state;
   logic [2:0]       w_next;
   logic [WIDTH-1:0] r_res_q;
   logic [WIDTH-1:0] r_stat_q;
   logic [CNT_W-1:0] r_pair_count;
   logic [CNT_W-1:0] r_err_count;
   logic             r_desync;

   logic w_res_nz;
   logic w_stat_nz;
   logic w_start;
   logic w_mismatch;
   logic w_hs;

   assign w_res_nz   = |result_pop;
   assign w_stat_nz  = |status_pop;
   assign w_start    = enable && w_res_nz && w_stat_nz;
   assign w_mismatch = w_res_nz != w_stat_nz;
   assign w_hs       = out_valid && out_ready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE:      if (w_start) w_next = c_POP;
         c_POP:       w_next = c_WAIT;
         c_WAIT:      w_next = c_SEND_RES;
         c_SEND_RES:  if (w_hs) w_next = c_SEND_STAT;
         c_SEND_STAT: if (w_hs) w_next = c_IDLE;
         default:     w_next = c_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= c_IDLE;
         r_res_q      <= '0;
         r_stat_q     <= '0;
         r_pair_count <= '0;
         r_err_count  <= '0;
         r_desync     <= 1'b0;
      end else begin
         r_state <= w_next;
         // FIFO read data becomes valid the cycle after the pop strobe
         if (r_state == c_WAIT) begin
            r_res_q  <= result_data;
            r_stat_q <= status_data;
         end
         if (clear_cnt) begin
            r_pair_count <= '0;
            r_err_count  <= '0;
            r_desync     <= 1'b0;
         end else begin
            if ((r_state == c_SEND_STAT) && w_hs) begin
               if (r_pair_count != c_CNT_MAX)
                  r_pair_count <= r_pair_count + 1'b1;
               if ((r_stat_q != '0) && (r_err_count != c_CNT_MAX))
                  r_err_count <= r_err_count + 1'b1;
            end
            if ((r_state == c_IDLE) && w_mismatch)
               r_desync <= 1'b1;
         end
      end
   end

   assign rd_en_result = (r_state == c_POP);
   assign rd_en_status = (r_state == c_POP);
   assign out_valid    = (r_state == c_SEND_RES) || (r_state == c_SEND_STAT);
   assign out_last     = (r_state == c_SEND_STAT);
   assign out_data     = (r_state == c_SEND_RES)  ? r_res_q  :
                         (r_state == c_SEND_STAT) ? r_stat_q : '0;
   assign busy         = (r_state != c_IDLE);
   assign pair_count   = r_pair_count;
   assign err_count    = r_err_count;
   assign desync       = r_desync;

endmodule
`default_nettype wire

// File: tb/tb_pea_result_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pea_result_drain
// Brief    : Randomised scoreboard bench for pea_result_drain with a queue
//            based FIFO model and a decoupled stream monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pea_result_drain;
   localparam int WIDTH = 32;
   localparam int POP_W = 5;
   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst, enable, clear_cnt, out_ready;
   logic [POP_W-1:0] result_pop, status_pop;
   logic [WIDTH-1:0] result_data, status_data, out_data;
   logic             rd_en_result, rd_en_status, out_valid, out_last, busy, desync;
   logic [CNT_W-1:0] pair_count, err_count;

   logic [31:0] rq[$];
   logic [31:0] sq[$];
   beat_t       exp_q[$];
   int          n_tests = 0, n_fail = 0, n_pops = 0;
   int          m_pair = 0, m_err = 0, extra_res = 0;

   always #5 clk = ~clk;

   pea_result_drain #(.WIDTH(WIDTH), .POP_W(POP_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .enable(enable), .clear_cnt(clear_cnt),
      .result_pop(result_pop), .status_pop(status_pop),
      .result_data(result_data), .status_data(status_data),
      .rd_en_result(rd_en_result), .rd_en_status(rd_en_status),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .pair_count(pair_count),
      .err_count(err_count), .desync(desync)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   task automatic update_pops();
      result_pop = POP_W'(rq.size() + extra_res);
      status_pop = POP_W'(sq.size());
   endtask

   task automatic push(input logic [31:0] r, input logic [31:0] s);
      rq.push_back(r);
      sq.push_back(s);
      exp_q.push_back('{d: r, l: 1'b0});
      exp_q.push_back('{d: s, l: 1'b1});
      update_pops();
   endtask

   // One clock: sample pop strobes mid-cycle, then model the FIFO read after the edge
   task automatic tick();
      logic rp, sp;
      @(negedge clk);
      rp = rd_en_result;
      sp = rd_en_status;
      @(posedge clk);
      #1;
      if (rp) begin
         chk("pop_result_nonempty", rq.size() != 0, 1);
         if (rq.size() != 0) result_data = rq.pop_front();
      end
      if (sp) begin
         chk("pop_status_nonempty", sq.size() != 0, 1);
         if (sq.size() != 0) status_data = sq.pop_front();
      end
      update_pops();
   endtask

   task automatic drain();
      int k = 0;
      out_ready = 1'b1;
      enable    = 1'b1;
      while ((rq.size() != 0 || exp_q.size() != 0 || busy) && k < 3000) begin
         tick();
         k++;
      end
      chk("drain_within_budget", k < 3000, 1);
   endtask

   task automatic wait_valid(input bit want_last);
      int k = 0;
      while (!(out_valid && (out_last == want_last)) && k < 20) begin
         tick();
         k++;
      end
      chk("wait_valid_budget", k < 20, 1);
   endtask

   // Stream monitor / scoreboard
   initial begin
      bit          prev_stall = 1'b0;
      logic [31:0] prev_d = '0;
      logic        prev_l = 1'b0;
      beat_t       b;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
            m_pair     = 0;
            m_err      = 0;
         end else begin
            if (rd_en_result || rd_en_status) begin
               chk("rd_en_lockstep", rd_en_result, rd_en_status);
               n_pops++;
            end
            if (prev_stall) begin
               chk("stall_valid", out_valid, 1);
               chk("stall_data", out_data, prev_d);
               chk("stall_last", out_last, prev_l);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_beat", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
               end else begin
                  b = exp_q.pop_front();
                  chk("beat_data", out_data, b.d);
                  chk("beat_last", out_last, b.l);
                  if (b.l && !clear_cnt) begin
                     if (m_pair < CMAX) m_pair++;
                     if (b.d != 0 && m_err < CMAX) m_err++;
                  end
               end
            end
            if (clear_cnt) begin
               m_pair = 0;
               m_err  = 0;
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_l     = out_last;
         end
      end
   end

   initial begin
      int p0, bc, first_v, sent;
      rst = 1'b1; enable = 1'b0; clear_cnt = 1'b0; out_ready = 1'b0;
      result_data = '0; status_data = '0;
      update_pops();
      repeat (3) tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd_en", {rd_en_result, rd_en_status}, 0);
      chk("rst_pair_count", pair_count, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_desync", desync, 0);
      rst = 1'b0;
      tick();

      // Single pair: latency and occupancy
      enable = 1'b1; out_ready = 1'b1;
      p0 = n_pops;
      push(32'h7, 32'h0);
      bc = 0; first_v = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (busy) bc++;
         if (out_valid && first_v == 0) first_v = i;
         if (i == 1) chk("single_rd_en_pulse", rd_en_result, 1);
         if (i == 2) chk("single_rd_en_drop", rd_en_result, 0);
      end
      chk("single_busy_cycles", bc, 4);
      chk("single_first_valid", first_v, 3);
      chk("single_pops", n_pops - p0, 1);
      chk("single_pair_count", pair_count, 1);
      chk("single_err_count", err_count, 0);

      // Three queued pairs
      enable = 1'b0;
      p0 = n_pops;
      push(10, 0); push(20, 2); push(30, 0);
      repeat (3) tick();
      chk("enable_low_blocks", busy, 0);
      drain();
      chk("three_pops", n_pops - p0, 3);
      chk("three_pair_count", pair_count, 4);
      chk("three_err_count", err_count, 1);

      // Backpressure during SEND_RES
      out_ready = 1'b0;
      p0 = n_pops;
      push(32'hA5A5_0001, 32'h3);
      wait_valid(1'b0);
      repeat (4) tick();
      chk("bp_valid_held", out_valid, 1);
      chk("bp_data_held", out_data, 32'hA5A5_0001);
      chk("bp_single_pop", n_pops - p0, 1);
      drain();
      chk("bp_pair_count", pair_count, 5);
      chk("bp_err_count", err_count, 2);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         if (rq.size() < 31 && $urandom_range(0, 2) == 0)
            push($urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 255)) : 32'h0);
         out_ready = 1'($urandom_range(0, 1));
         enable    = ($urandom_range(0, 4) != 0);
         clear_cnt = ($urandom_range(0, 80) == 0);
         tick();
      end
      clear_cnt = 1'b0;
      drain();
      chk("rand_pair_count", pair_count, m_pair);
      chk("rand_err_count", err_count, m_err);
      chk("rand_scoreboard_empty", exp_q.size(), 0);

      // FIFO desynchronisation
      clear_cnt = 1'b1; tick(); clear_cnt = 1'b0;
      p0 = n_pops;
      extra_res = 1; update_pops();
      repeat (3) tick();
      chk("desync_set", desync, 1);
      chk("desync_no_start", busy, 0);
      chk("desync_no_pop", n_pops - p0, 0);
      extra_res = 0; update_pops();
      tick();
      chk("desync_sticky", desync, 1);
      clear_cnt = 1'b1; tick(); clear_cnt = 1'b0;
      chk("desync_cleared", desync, 0);

      // Reset while stalled in SEND_RES abandons the pair
      out_ready = 1'b0;
      p0 = n_pops;
      push(32'h1234, 32'h5);
      wait_valid(1'b0);
      rst = 1'b1;
      exp_q.delete();
      tick();
      rst = 1'b0;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_pair_count", pair_count, 0);
      chk("midrst_pops", n_pops - p0, 1);
      chk("midrst_fifo_pop", result_pop, 0);
      tick();
      chk("midrst_no_reemit", out_valid, 0);

      // Saturation, then clear colliding with the final handshake
      out_ready = 1'b1; enable = 1'b1;
      sent = 0;
      while (sent < CMAX + 1) begin
         if (rq.size() < 31) begin
            push(32'(sent + 1), 32'h1);
            sent++;
         end
         tick();
      end
      drain();
      chk("sat_pair_count", pair_count, CMAX);
      chk("sat_err_count", err_count, CMAX);
      chk("sat_model_pair", pair_count, m_pair);
      push(32'hBEEF, 32'h1);
      wait_valid(1'b1);
      clear_cnt = 1'b1;
      tick();
      clear_cnt = 1'b0;
      chk("clear_wins_pair", pair_count, 0);
      chk("clear_wins_err", err_count, 0);
      drain();
      chk("final_scoreboard_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
